mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus bundle between the MEM stage (master) and the memory/bus fabric (slave).
// Request side: bus_req, bus_we, bus_addr, bus_be, bus_wdata.
// Response side: bus_ack, bus_rdata.
interface mem_stage_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs one bus transaction per load/store through an IDLE/REQ/DONE
// handshake and stalls upstream until the data is back.
// Misaligned accesses are dropped, flagged on mem_align_err, and their register write is
// suppressed.
// Optional feature: define MEM_SUBWORD_EN to enable byte and halfword accesses. With it
// undefined, every access is a word access and X_MemSize/X_MemSigned are ignored.
module mem_stage (
   input  logic        clk,
   input  logic        clrn,
   input  logic        X_MemRead,
   input  logic        X_MemWrite,
   input  logic [1:0]  X_MemSize,
   input  logic        X_MemSigned,
   input  logic [31:0] X_AluOut,
   input  logic [31:0] X_StoreData,
   input  logic        X_RegWrite,
   input  logic        X_M2Reg,
   input  logic [4:0]  X_TargetReg,
   output logic [31:0] M_MemOut,
   output logic [31:0] M_AluOut,
   output logic [4:0]  M_TargetReg,
   output logic        M_RegWrite,
   output logic        M_M2Reg,
   output logic        mem_stall,
   output logic        mem_align_err,
   mem_stage_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, nextState;
   logic        access, misaligned;
   logic        capture, latchLoad, stallInt, alignErrInt;
   logic [3:0]  beNext;
   logic [31:0] wdataNext, loadData;

   // Captured request, held stable for the whole REQ phase.
   logic [31:0] addrReg;
   logic [3:0]  beReg;
   logic        weReg;
   logic [31:0] wdataReg;
   logic [31:0] loadBuf;

   assign access = X_MemRead | X_MemWrite;

`ifdef MEM_SUBWORD_EN
   logic [1:0]  offReg;
   logic [1:0]  sizeReg;
   logic        signedReg;
   logic [31:0] shifted;

   // Alignment rule depends on access size: bytes never fault, halves need addr[0]=0.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      misaligned = 1'b0;
      case (X_MemSize)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = X_AluOut[0];
         default: misaligned = |X_AluOut[1:0];
      endcase
   end

   // Store lane steering: replicate sub-word data and enable only the addressed lanes.
   always_comb begin
      beNext    = 4'b1111;
      wdataNext = X_StoreData;
      if (X_MemWrite) begin
         case (X_MemSize)
            2'b00: begin
               beNext    = 4'b0001 << X_AluOut[1:0];
               wdataNext = {4{X_StoreData[7:0]}};
            end
            2'b01: begin
               beNext    = 4'b0011 << X_AluOut[1:0];
               wdataNext = {2{X_StoreData[15:0]}};
            end
            default: begin
               beNext    = 4'b1111;
               wdataNext = X_StoreData;
            end
         endcase
      end
   end

   // Load alignment: bring the addressed lane down to bit 0, then extend to 32 bits.
   always_comb begin
      shifted  = bus.bus_rdata >> {offReg, 3'b000};
      loadData = shifted;
      case (sizeReg)
         2'b00:   loadData = {{24{signedReg & shifted[7]}}, shifted[7:0]};
         2'b01:   loadData = {{16{signedReg & shifted[15]}}, shifted[15:0]};
         default: loadData = shifted;
      endcase
   end

   // Size/sign/offset of the captured access, used when the read data returns.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         offReg    <= 2'b00;
         sizeReg   <= 2'b00;
         signedReg <= 1'b0;
      end else if (capture) begin
         offReg    <= X_AluOut[1:0];
         sizeReg   <= X_MemSize;
         signedReg <= X_MemSigned;
      end
   end
`else
   // Word-only build: the size/sign controls have no effect.
   logic unusedCfgBits;
   assign unusedCfgBits = &{1'b0, X_MemSize, X_MemSigned};
   assign misaligned    = |X_AluOut[1:0];
   assign beNext        = 4'b1111;
   assign wdataNext     = X_StoreData;
   assign loadData      = bus.bus_rdata;
`endif

   // Next-state and stall/error decode; bus_ack only counts while a request is open.
   always_comb begin
      nextState   = state;
      stallInt    = 1'b0;
      alignErrInt = 1'b0;
      capture     = 1'b0;
      latchLoad   = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  alignErrInt = 1'b1;
               end else begin
                  capture   = 1'b1;
                  stallInt  = 1'b1;
                  nextState = REQ;
               end
            end
         end
         REQ: begin
            stallInt = 1'b1;
            if (bus.bus_ack) begin
               latchLoad = ~weReg;
               nextState = DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register; reset drops any open request immediately.
   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!clrn) state <= IDLE;
      else       state <= nextState;
   end

   // Request capture on entry to REQ.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         addrReg  <= '0;
         beReg    <= '0;
         weReg    <= 1'b0;
         wdataReg <= '0;
      end else if (capture) begin
         addrReg  <= {X_AluOut[31:2], 2'b00};
         beReg    <= X_MemWrite ? beNext : 4'b1111;
         weReg    <= X_MemWrite;
         wdataReg <= wdataNext;
      end
   end

   // Load buffer: updated only by an acknowledged read, cleared by reset.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)          loadBuf <= '0;
      else if (latchLoad) loadBuf <= loadData;
   end

   // Stall and error are forced low while reset is asserted, whatever the inputs show.
   assign mem_stall     = clrn & stallInt;
   assign mem_align_err = clrn & alignErrInt;

   assign bus.bus_req   = (state == REQ);
   assign bus.bus_we    = (state == REQ) & weReg;
   assign bus.bus_addr  = addrReg;
   assign bus.bus_be    = beReg;
   assign bus.bus_wdata = wdataReg;

   assign M_MemOut    = loadBuf;
   assign M_AluOut    = X_AluOut;
   assign M_TargetReg = X_TargetReg;
   assign M_M2Reg     = X_M2Reg;
   assign M_RegWrite  = X_RegWrite & ~mem_align_err;

endmodule
